// File: rtl/jtag_dm_core.sv
// RISC-V 0.13 Debug Module back end: takes DMI requests from the JTAG DTM over a
// level/busy 4-phase handshake and drives the core's halt, reset, GPR and system-bus ports.
module jtag_dm_core #(
  parameter int DMI_ADDR_BITS = 6,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int REQ_BITS      = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dtm_req_valid,
  input  logic [REQ_BITS-1:0] dtm_req_data,
  output logic                dm_is_busy,
  output logic [REQ_BITS-1:0] dm_resp_data,
  output logic                dm_halt_req,
  output logic                dm_reset_req,
  output logic                dm_reg_we,
  output logic [4:0]          dm_reg_addr,
  output logic [31:0]         dm_reg_wdata,
  input  logic [31:0]         dm_reg_rdata,
  output logic                dm_mem_req,
  output logic                dm_mem_we,
  output logic [31:0]         dm_mem_addr,
  output logic [31:0]         dm_mem_wdata,
  input  logic [31:0]         dm_mem_rdata
);

  typedef struct packed {
    logic [DMI_ADDR_BITS-1:0] addr;
    logic [DMI_DATA_BITS-1:0] data;
    logic [DMI_OP_BITS-1:0]   op;
  } dmi_req_t;

  typedef enum logic [2:0] {IDLE, EXEC, MEM, DONE, WAIT_LOW} state_t;

  localparam logic [DMI_ADDR_BITS-1:0] A_DATA0      = DMI_ADDR_BITS'('h04);
  localparam logic [DMI_ADDR_BITS-1:0] A_DMCONTROL  = DMI_ADDR_BITS'('h10);
  localparam logic [DMI_ADDR_BITS-1:0] A_DMSTATUS   = DMI_ADDR_BITS'('h11);
  localparam logic [DMI_ADDR_BITS-1:0] A_ABSTRACTCS = DMI_ADDR_BITS'('h16);
  localparam logic [DMI_ADDR_BITS-1:0] A_COMMAND    = DMI_ADDR_BITS'('h17);
  localparam logic [DMI_ADDR_BITS-1:0] A_SBCS       = DMI_ADDR_BITS'('h38);
  localparam logic [DMI_ADDR_BITS-1:0] A_SBADDRESS0 = DMI_ADDR_BITS'('h39);
  localparam logic [DMI_ADDR_BITS-1:0] A_SBDATA0    = DMI_ADDR_BITS'('h3C);
  localparam logic [DMI_OP_BITS-1:0]   OP_READ      = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0]   OP_WRITE     = DMI_OP_BITS'(2);

  state_t   state, state_nxt;
  dmi_req_t req;
  logic     v_meta, v_s, v_s_d, rise;
  logic     mem_phase;
  logic [31:0] rdata, rd_val, data0, sbaddr;
  logic     haltreq, ndmreset, dmactive;
  logic [2:0] cmderr;
  logic     sb_autoinc, sb_readondata;
  logic     is_read, is_write, sb_bus, cmd_go, cmd_type_ok, cmd_size_ok, cmd_regno_ok;
  logic     cmd_xfer, cmd_err;

  // Two-flop synchroniser on the TCK-domain request level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_meta <= 1'b0;
      v_s    <= 1'b0;
      v_s_d  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      v_meta <= dtm_req_valid;
      v_s    <= v_meta;
      v_s_d  <= v_s;
    end
  end

  assign rise = v_s & ~v_s_d;

  assign is_read  = (req.op == OP_READ);
  assign is_write = (req.op == OP_WRITE);
  assign sb_bus   = dmactive & (req.addr == A_SBDATA0) & (is_read | is_write);

  // Abstract command decode: only 32-bit GPR transfers are supported.
  assign cmd_go       = dmactive & is_write & (req.addr == A_COMMAND) & (cmderr == 3'd0);
  assign cmd_type_ok  = (req.data[31:24] == 8'd0);
  assign cmd_size_ok  = (req.data[22:20] == 3'd2);
  assign cmd_regno_ok = (req.data[15:5] == 11'h080);
  assign cmd_xfer     = cmd_go & cmd_type_ok & req.data[17] & cmd_size_ok & cmd_regno_ok;
  assign cmd_err      = cmd_go & ~(cmd_type_ok & (~req.data[17] | (cmd_size_ok & cmd_regno_ok)));

  always_comb begin
    rd_val = '0;
    case (req.addr)
      A_DATA0:      rd_val = data0;
      A_DMCONTROL:  rd_val = {haltreq, 29'b0, ndmreset, dmactive};
      A_DMSTATUS:   rd_val = {20'b0, ~haltreq, ~haltreq, haltreq, haltreq, 1'b1, 3'b0, 4'd2};
      A_ABSTRACTCS: rd_val = {3'b0, 5'd0, 11'b0, 1'b0, 1'b0, cmderr, 4'b0, 4'd1};
      A_SBCS:       rd_val = {3'd1, 9'b0, 3'd2, sb_autoinc, sb_readondata, 3'b0, 7'd32, 2'b0, 1'b1, 2'b0};
      A_SBADDRESS0: rd_val = sbaddr;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no inferred latches).
    state_nxt  = state;
    dm_reg_we  = 1'b0;
    dm_mem_req = 1'b0;
    dm_mem_we  = 1'b0;
    unique case (state)
      IDLE:     if (rise) state_nxt = EXEC;
      EXEC: begin
        dm_reg_we = cmd_xfer & req.data[16];
        state_nxt = sb_bus ? MEM : DONE;
      end
      MEM: begin
        dm_mem_req = ~mem_phase;
        dm_mem_we  = ~mem_phase & is_write;
        if (is_write || mem_phase) state_nxt = DONE;
      end
      DONE:     state_nxt = WAIT_LOW;
      WAIT_LOW: if (!v_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req           <= '0;
      dm_is_busy    <= 1'b0;
      dm_resp_data  <= '0;
      rdata         <= '0;
      mem_phase     <= 1'b0;
      data0         <= '0;
      haltreq       <= 1'b0;
      ndmreset      <= 1'b0;
      dmactive      <= 1'b0;
      cmderr        <= '0;
      sb_autoinc    <= 1'b0;
      sb_readondata <= 1'b0;
      sbaddr        <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          req        <= dtm_req_data;
          dm_is_busy <= 1'b1;
        end
        EXEC: begin
          mem_phase <= 1'b0;
          rdata     <= (is_read && !sb_bus) ? rd_val : '0;
          if (is_write) begin
            case (req.addr)
              A_DATA0:      data0 <= req.data;
              A_DMCONTROL: begin
                dmactive <= req.data[0];
                haltreq  <= req.data[31] & req.data[0];
                ndmreset <= req.data[1] & req.data[0];
              end
              A_ABSTRACTCS: cmderr <= cmderr & ~req.data[10:8];
              A_COMMAND: begin
                if (cmd_err) cmderr <= 3'd2;
                if (cmd_xfer && !req.data[16]) data0 <= dm_reg_rdata;
              end
              A_SBCS: begin
                sb_autoinc    <= req.data[16];
                sb_readondata <= req.data[15];
              end
              A_SBADDRESS0: sbaddr <= req.data;
              default: ;
            endcase
          end
        end
        MEM: begin
          // Reads take a second cycle: bus data is valid the cycle after the strobe.
          if (is_write) begin
            if (sb_autoinc) sbaddr <= sbaddr + 32'd4;
          end else if (!mem_phase) begin
            mem_phase <= 1'b1;
          end else begin
            rdata     <= dm_mem_rdata;
            mem_phase <= 1'b0;
            if (sb_autoinc) sbaddr <= sbaddr + 32'd4;
          end
        end
        DONE:     dm_resp_data <= {req.addr, rdata, DMI_OP_BITS'(0)};
        WAIT_LOW: if (!v_s) dm_is_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dm_halt_req  = haltreq;
  assign dm_reset_req = ndmreset;
  assign dm_reg_addr  = req.data[4:0];
  assign dm_reg_wdata = data0;
  assign dm_mem_addr  = sbaddr;
  assign dm_mem_wdata = req.data;

endmodule

// File: tb/tb_jtag_dm_core.sv
// Self-checking bench for jtag_dm_core: directed vector table, hand sequences for the
// multi-cycle corners, and random DMI traffic against a register-map level model.
module tb_jtag_dm_core;

  logic        clk;
  logic        rst_n;
  logic        dtm_req_valid;
  logic [39:0] dtm_req_data;
  logic        dm_is_busy;
  logic [39:0] dm_resp_data;
  logic        dm_halt_req, dm_reset_req;
  logic        dm_reg_we;
  logic [4:0]  dm_reg_addr;
  logic [31:0] dm_reg_wdata, dm_reg_rdata;
  logic        dm_mem_req, dm_mem_we;
  logic [31:0] dm_mem_addr, dm_mem_wdata, dm_mem_rdata;

  jtag_dm_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dtm_req_valid(dtm_req_valid),
    .dtm_req_data (dtm_req_data),
    .dm_is_busy   (dm_is_busy),
    .dm_resp_data (dm_resp_data),
    .dm_halt_req  (dm_halt_req),
    .dm_reset_req (dm_reset_req),
    .dm_reg_we    (dm_reg_we),
    .dm_reg_addr  (dm_reg_addr),
    .dm_reg_wdata (dm_reg_wdata),
    .dm_reg_rdata (dm_reg_rdata),
    .dm_mem_req   (dm_mem_req),
    .dm_mem_we    (dm_mem_we),
    .dm_mem_addr  (dm_mem_addr),
    .dm_mem_wdata (dm_mem_wdata),
    .dm_mem_rdata (dm_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Core-side environment: GPR file and a bus that answers one cycle after the strobe.
  logic [31:0] gpr [32];
  logic [31:0] mem_rd_val = 32'h0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          we_cnt = 0, mem_cnt = 0;
  logic [4:0]  we_addr = '0;
  logic [31:0] we_data = '0, mem_addr = '0, mem_wdata = '0;
  logic        mem_we = 1'b0;

  assign dm_reg_rdata = gpr[dm_reg_addr];

  initial dm_mem_rdata = 32'hDEAD_0BAD;

  always @(negedge clk) begin
    if (dm_reg_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= dm_reg_addr;
      we_data <= dm_reg_wdata;
    end
    if (dm_mem_req) begin
      mem_cnt  <= mem_cnt + 1;
      mem_we   <= dm_mem_we;
      mem_addr <= dm_mem_addr;
      if (dm_mem_we) mem_wdata <= dm_mem_wdata;
    end
    dm_mem_rdata <= prev_req ? (mem_rd_val ^ prev_addr) : 32'hDEAD_0BAD;
    prev_req     <= dm_mem_req;
    prev_addr    <= dm_mem_addr;
  end

  // Register-map model of the debug module.
  logic [31:0] m_data0, m_sbaddr;
  logic        m_halt, m_ndm, m_active, m_autoinc, m_rod;
  logic [2:0]  m_cmderr;
  int          exp_we_cnt = 0, exp_mem_cnt = 0;
  logic [4:0]  exp_we_addr = '0;
  logic [31:0] exp_we_data = '0, exp_mem_addr = '0, exp_mem_wdata = '0;
  logic        exp_mem_we = 1'b0;

  task automatic model_reset();
    m_data0 = 0; m_sbaddr = 0; m_halt = 0; m_ndm = 0; m_active = 0;
    m_autoinc = 0; m_rod = 0; m_cmderr = 0;
  endtask

  task automatic sb_access(input logic wr, input logic [31:0] wd);
    exp_mem_cnt++;
    exp_mem_we   = wr;
    exp_mem_addr = m_sbaddr;
    if (wr) exp_mem_wdata = wd;
    if (m_autoinc) m_sbaddr = m_sbaddr + 32'd4;
  endtask

  task automatic model_dmi(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                           output logic [31:0] rd);
    int regno;
    rd = 0;
    if (op == 2'b01) begin
      case (a)
        6'h04: rd = m_data0;
        6'h10: rd = (32'(m_halt) << 31) | (32'(m_ndm) << 1) | 32'(m_active);
        6'h11: rd = 32'd2 | (32'd1 << 7) | (m_halt ? (32'd3 << 8) : (32'd3 << 10));
        6'h16: rd = (32'(m_cmderr) << 8) | 32'd1;
        6'h38: rd = (32'd1 << 29) | (32'd2 << 17) | (32'(m_autoinc) << 16) | (32'(m_rod) << 15)
                    | (32'd32 << 5) | 32'd4;
        6'h39: rd = m_sbaddr;
        6'h3C: if (m_active) begin
          rd = mem_rd_val ^ m_sbaddr;
          sb_access(1'b0, 0);
        end
        default: rd = 0;
      endcase
    end else if (op == 2'b10) begin
      case (a)
        6'h04: m_data0 = d;
        6'h10: begin m_active = d[0]; m_halt = d[31] & d[0]; m_ndm = d[1] & d[0]; end
        6'h16: m_cmderr = m_cmderr & ~d[10:8];
        6'h17: if (m_active && m_cmderr == 0) begin
          regno = int'(d[15:0]);
          if (d[31:24] != 0) m_cmderr = 2;
          else if (d[17]) begin
            if (d[22:20] != 2 || regno < 'h1000 || regno > 'h101F) m_cmderr = 2;
            else if (d[16]) begin
              exp_we_cnt++;
              exp_we_addr = d[4:0];
              exp_we_data = m_data0;
            end else m_data0 = gpr[d[4:0]];
          end
        end
        6'h38: begin m_autoinc = d[16]; m_rod = d[15]; end
        6'h39: m_sbaddr = d;
        6'h3C: if (m_active) sb_access(1'b1, d);
        default: ;
      endcase
    end
  endtask

  task automatic check_side();
    check("halt_req", dm_halt_req, m_halt);
    check("reset_req", dm_reset_req, m_ndm);
    check("reg_we_cnt", we_cnt, exp_we_cnt);
    check("reg_we_addr", we_addr, exp_we_addr);
    check("reg_we_data", we_data, exp_we_data);
    check("mem_cnt", mem_cnt, exp_mem_cnt);
    check("mem_we", mem_we, exp_mem_we);
    check("mem_addr", mem_addr, exp_mem_addr);
    check("mem_wdata", mem_wdata, exp_mem_wdata);
  endtask

  // One full 4-phase DMI transaction; valid is held 'hold' cycles after busy is seen.
  task automatic dmi(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                     input int hold, output logic [31:0] got);
    logic [31:0] exp;
    int n, drops;
    model_dmi(a, d, op, exp);
    @(negedge clk);
    dtm_req_data  = {a, d, op};
    dtm_req_valid = 1'b1;
    n = 0;
    while (!dm_is_busy && n < 4) begin @(negedge clk); n++; end
    check("busy_rise", dm_is_busy, 1);
    drops = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!dm_is_busy) drops++;
    end
    check("busy_held", drops, 0);
    dtm_req_valid = 1'b0;
    n = 0;
    while (dm_is_busy && n < 16) begin @(negedge clk); n++; end
    check("busy_fall", dm_is_busy, 0);
    check("resp", dm_resp_data, {a, exp, 2'b00});
    got = dm_resp_data[33:2];
    check_side();
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
    logic [31:0] exp_rdata;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, d, exp;
    logic [5:0]  a;
    logic [1:0]  op;
    logic [5:0]  pool [10];
    int          base_we, base_mem, n;

    tbl[0]  = '{6'h11, 32'h0000_0000, 2'b01, 32'h0000_0C82, 1'b0};
    tbl[1]  = '{6'h10, 32'h8000_0001, 2'b10, 32'h0000_0000, 1'b1};
    tbl[2]  = '{6'h11, 32'h0000_0000, 2'b01, 32'h0000_0382, 1'b1};
    tbl[3]  = '{6'h10, 32'h0000_0000, 2'b01, 32'h8000_0001, 1'b1};
    tbl[4]  = '{6'h10, 32'h0000_0001, 2'b10, 32'h0000_0000, 1'b0};
    tbl[5]  = '{6'h11, 32'h0000_0000, 2'b01, 32'h0000_0C82, 1'b0};
    tbl[6]  = '{6'h04, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b0};
    tbl[7]  = '{6'h04, 32'h0000_0000, 2'b01, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{6'h16, 32'h0000_0000, 2'b01, 32'h0000_0001, 1'b0};
    tbl[9]  = '{6'h38, 32'h0000_0000, 2'b01, 32'h2004_0404, 1'b0};
    tbl[10] = '{6'h2A, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000, 1'b0};
    tbl[11] = '{6'h2A, 32'h0000_0000, 2'b01, 32'h0000_0000, 1'b0};
    tbl[12] = '{6'h04, 32'h1234_5678, 2'b00, 32'h0000_0000, 1'b0};
    tbl[13] = '{6'h04, 32'h0000_0000, 2'b11, 32'h0000_0000, 1'b0};
    tbl[14] = '{6'h04, 32'h0000_0000, 2'b01, 32'hDEAD_BEEF, 1'b0};
    tbl[15] = '{6'h17, 32'h0000_0000, 2'b01, 32'h0000_0000, 1'b0};

    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    model_reset();
    rst_n = 1'b0;
    dtm_req_valid = 1'b0;
    dtm_req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", dm_is_busy, 0);
    check("rst_resp", dm_resp_data, 0);
    check("rst_outputs", |{dm_halt_req, dm_reset_req, dm_reg_we, dm_reg_addr, dm_reg_wdata,
                           dm_mem_req, dm_mem_we, dm_mem_addr, dm_mem_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      dmi(tbl[i].addr, tbl[i].data, tbl[i].op, 1, got);
      check($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_halt", i), dm_halt_req, tbl[i].exp_halt);
    end

    // Abstract command: GPR write, GPR read, unsupported command and cmderr clear.
    base_we = we_cnt;
    dmi(6'h17, 32'h0023_1005, 2'b10, 1, got);
    check("cmd_wr_pulses", we_cnt - base_we, 1);
    check("cmd_wr_addr", we_addr, 5);
    check("cmd_wr_data", we_data, 32'hDEAD_BEEF);
    gpr[5] = 32'h1234_5678;
    dmi(6'h17, 32'h0022_1005, 2'b10, 1, got);
    dmi(6'h04, 32'h0, 2'b01, 1, got);
    check("cmd_rd_data0", got, 32'h1234_5678);
    dmi(6'h17, 32'h0100_0000, 2'b10, 1, got);
    dmi(6'h16, 32'h0, 2'b01, 1, got);
    check("cmderr_set", got, 32'h0000_0201);
    check("cmderr_no_we", we_cnt - base_we, 1);
    dmi(6'h16, 32'h0000_0700, 2'b10, 1, got);
    dmi(6'h16, 32'h0, 2'b01, 1, got);
    check("cmderr_clr", got, 32'h0000_0001);

    // System bus: autoincrement wrap on write, read data one cycle after the strobe.
    base_mem = mem_cnt;
    dmi(6'h38, 32'h0001_0000, 2'b10, 1, got);
    dmi(6'h39, 32'hFFFF_FFFC, 2'b10, 1, got);
    dmi(6'h3C, 32'hA5A5_A5A5, 2'b10, 1, got);
    check("sb_wr_cnt", mem_cnt - base_mem, 1);
    check("sb_wr_we", mem_we, 1);
    check("sb_wr_addr", mem_addr, 32'hFFFF_FFFC);
    check("sb_wr_data", mem_wdata, 32'hA5A5_A5A5);
    dmi(6'h39, 32'h0, 2'b01, 1, got);
    check("sb_wrap", got, 32'h0);
    mem_rd_val = 32'h1122_3344;
    dmi(6'h3C, 32'h0, 2'b01, 1, got);
    check("sb_rd_data", got, 32'h1122_3344);
    check("sb_rd_we", mem_we, 0);
    dmi(6'h39, 32'h0, 2'b01, 1, got);
    check("sb_inc", got, 32'h4);

    // Valid held long after the response: exactly one execution.
    base_we = we_cnt;
    dmi(6'h17, 32'h0023_1005, 2'b10, 20, got);
    check("hold_one_exec", we_cnt - base_we, 1);

    // Reset in the middle of a bus read, with valid still held.
    dmi(6'h10, 32'h8000_0003, 2'b10, 1, got);
    dmi(6'h39, 32'h0000_0100, 2'b10, 1, got);
    mem_rd_val = 32'h0BAD_F00D;
    @(negedge clk);
    dtm_req_data  = {6'h3C, 32'h0, 2'b01};
    dtm_req_valid = 1'b1;
    n = 0;
    while (!dm_mem_req && n < 10) begin @(negedge clk); n++; end
    check("mid_mem_req", dm_mem_req, 1);
    #1 rst_n = 1'b0;
    exp_mem_cnt++;
    exp_mem_we   = 1'b0;
    exp_mem_addr = 32'h0000_0100;
    #1;
    check("midrst_busy", dm_is_busy, 0);
    check("midrst_resp", dm_resp_data, 0);
    check("midrst_outputs", |{dm_halt_req, dm_reset_req, dm_reg_we, dm_reg_addr, dm_reg_wdata,
                              dm_mem_req, dm_mem_we, dm_mem_addr, dm_mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_dmi(6'h3C, 32'h0, 2'b01, exp);
    n = 0;
    while (!dm_is_busy && n < 6) begin @(negedge clk); n++; end
    check("reexec_busy", dm_is_busy, 1);
    dtm_req_valid = 1'b0;
    n = 0;
    while (dm_is_busy && n < 16) begin @(negedge clk); n++; end
    check("reexec_done", dm_is_busy, 0);
    check("reexec_resp", dm_resp_data, {6'h3C, exp, 2'b00});
    check_side();

    // Random traffic against the model.
    pool = '{6'h04, 6'h10, 6'h11, 6'h16, 6'h17, 6'h38, 6'h39, 6'h3C, 6'h3C, 6'h17};
    for (int i = 0; i < 150; i++) begin
      for (int g = 0; g < 32; g++) gpr[g] = $urandom;
      mem_rd_val = $urandom;
      a  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (a == 6'h10 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
      if (a == 6'h17) begin
        case ($urandom_range(0, 3))
          0, 1: d = {8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 1'($urandom_range(0, 1)),
                     16'h1000 + 16'($urandom_range(0, 31))};
          2: d = $urandom;
          default: d = {8'h00, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 16'h0FF0 + 16'($urandom_range(0, 63))};
        endcase
      end
      dmi(a, d, op, $urandom_range(0, 6), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_dm_core.md
Name: jtag_dm_core

Overview:
- Debug Module back end in the core clock domain, directly downstream of the JTAG DTM.
- Receives DMI requests over a level-valid, busy-acknowledged 4-phase handshake crossing from the TCK domain.
- Decodes the RISC-V 0.13 DM registers it implements and drives the halt, reset, GPR-access and system-bus memory ports of the core.
- Returns the DMI response word to the DTM.

Parameters:
- DMI_ADDR_BITS, 6, DMI address width.
- DMI_DATA_BITS, 32, DMI data width.
- DMI_OP_BITS, 2, DMI op width.
- REQ_BITS, DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS, request/response word width.

Ports:
- clk  in  1  core clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- dtm_req_valid  in  1  TCK-domain request level; async, must be synchronised.
- dtm_req_data  in  REQ_BITS  {addr[39:34], data[33:2], op[1:0]}; stable while dtm_req_valid is high.
- dm_is_busy  out  1  registered; high from capture until the handshake completes.
- dm_resp_data  out  REQ_BITS  {addr, rdata, op=2'b00}; registered.
- dm_halt_req  out  1  halt request to the core.
- dm_reset_req  out  1  non-debug-module reset of the core.
- dm_reg_we  out  1  GPR write strobe, 1 cycle.
- dm_reg_addr  out  5  GPR index.
- dm_reg_wdata  out  32  GPR write data.
- dm_reg_rdata  in  32  GPR read data; combinational from dm_reg_addr.
- dm_mem_req  out  1  system-bus access strobe, 1 cycle.
- dm_mem_we  out  1  write qualifier for dm_mem_req.
- dm_mem_addr  out  32  word address.
- dm_mem_wdata  out  32  write data.
- dm_mem_rdata  in  32  read data; valid the cycle after dm_mem_req.

Behaviour:
- Reset: all outputs 0. Registers, FSM and synchroniser flops 0.
- Synchroniser: dtm_req_valid passes through 2 flops to give v_s. rise = v_s & ~v_s_d.
- FSM states: IDLE, EXEC, MEM, DONE, WAIT_LOW.
- IDLE: on rise, capture dtm_req_data into req, set dm_is_busy=1, go to EXEC.
- EXEC (1 cycle), by req.op:
  - op=00 (nop): rdata=0, go to DONE.
  - op=01 (read): read the selected register into rdata. sbdata0 reads go to MEM instead.
  - op=10 (write): write the selected register, then go to DONE, except:
    - command write performs a GPR access.
    - sbdata0 write goes to MEM.
  - op=11: treated as nop.
- Register map; unlisted addresses read 0 and ignore writes:
  - 0x04 data0: R/W 32 bits.
  - 0x10 dmcontrol: bit31 haltreq maps to dm_halt_req; bit1 ndmreset maps to dm_reset_req; bit0 dmactive is R/W. Reads return these bits only.
  - 0x11 dmstatus: RO. version[3:0]=2, authenticated bit7=1, anyhalted bit8 = allhalted bit9 = dm_halt_req, anyrunning bit10 = allrunning bit11 = ~dm_halt_req.
  - 0x16 abstractcs: RO = {3'b0, progbufsize=0, 11'b0, busy=0, 1'b0, cmderr[10:8], 4'b0, datacount[3:0]=1}. Writing 1 to any cmderr bit clears that bit.
  - 0x17 command: WO. Valid access is cmdtype[31:24]=0, aarsize[22:20]=2, transfer bit17=1, regno in 0x1000..0x101F.
    - write bit16=1: dm_reg_we pulses in EXEC with addr=regno[4:0] and wdata=data0.
    - write bit16=0: data0 <= dm_reg_rdata.
    - transfer=0: no action.
    - Any other value: cmderr=2 (not supported), no access.
    - cmderr!=0 on entry: command ignored.
  - 0x38 sbcs: R/W bit16 sbautoincrement and bit15 sbreadondata. RO fields: sbversion[31:29]=1, sbaccess[19:17]=2, sbasize[11:5]=32, sbaccess32 bit2=1.
  - 0x39 sbaddress0: R/W. Write with sbreadondata=1 issues no read; reads only trigger from sbdata0.
  - 0x3C sbdata0: R/W via the bus.
- MEM state:
  - Pulse dm_mem_req with addr=sbaddress0. Write: we=1, wdata=req.data.
  - Read: next cycle latch dm_mem_rdata into sbdata0 and rdata.
  - After the access, if sbautoincrement=1: sbaddress0 += 4, wrapping mod 2^32.
  - Go to DONE. Occupancy: 2 cycles for read, 1 for write.
- DONE: dm_resp_data <= {req.addr, rdata, 2'b00}, go to WAIT_LOW. dm_is_busy stays 1.
- WAIT_LOW: when v_s=0, clear dm_is_busy and go to IDLE.
  - A rise cannot occur here. v_s must fall first; the DTM drops valid when it sees busy.
- Ordering: dm_resp_data is stable before dm_is_busy falls, for the DTM's next CAPTURE_DR.
- Write data in DONE is not echoed: rdata=0 for writes.
- dmactive=0 holds haltreq and ndmreset at 0 and ignores command and sb accesses. Those accesses still complete the handshake with a response.
- Reset mid-transaction: everything returns to reset values.
  - If valid is still high after reset, v_s rises and the held request is re-executed.
  - This re-execution is expected behaviour.

Test Plan:
- Reset then read 0x11 (op=01): response data=0x00000C82 (version 2, authenticated, allrunning, anyrunning), op=00. Busy rises within 4 clk of the valid rise and falls only after valid drops.
- Write 0x10=0x80000001, then read 0x11: dm_halt_req=1, dmstatus=0x00000382. Write 0x10=0x00000001: dm_halt_req=0.
- With dmactive=1: write data0=0xDEADBEEF, write command=0x00231005. Expect dm_reg_we pulse, addr=5, wdata=0xDEADBEEF. Command 0x00221005 with rdata=0x12345678 gives data0=0x12345678.
- Command=0x01000000: cmderr=2 in abstractcs and no dm_reg_we. Write abstractcs=0x700 clears cmderr to 0.
- sbcs bit16=1, sbaddress0=0xFFFFFFFC, sbdata0 write 0xA5A5A5A5: mem_req, we=1, addr=0xFFFFFFFC, then sbaddress0=0x00000000 (wrap). sbdata0 read with mem_rdata=0x11223344 returns 0x11223344 and addr advances to 4.
- Hold valid high 20 cycles after the response: no second execution. Reset pulse mid-MEM: all outputs 0; the held request re-executes after release.
